// File: rtl/lii_mem_endpoint.sv
// LII slave endpoint: services READ/WRITE request packets against a local byte memory.
// Latency: header-to-first-read-data valid 2 cycles; read beats every 2 cycles; write ack 1 cycle after last beat.
// Backpressure: request ready only in IDLE/WR/DRAIN; response fields held stable until resp_tready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   lii_req_*           request stream (header flit, then write data beats)
//   lii_resp_*          response stream (read data beats or one ack flit)
//   cfg_src             this endpoint's id, driven on lii_resp_src
module lii_mem_endpoint #(
  parameter int LII_DW = 64,
  parameter int HDR_AW = 40,
  parameter int MEM_AW = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LII_DW-1:0]   lii_req_tdata,
  input  logic [LII_DW/8-1:0] lii_req_tkeep,
  input  logic [LII_DW/8-1:0] lii_req_tstrb,
  input  logic                lii_req_tlast,
  input  logic [7:0]          lii_req_src,
  input  logic [7:0]          lii_req_dst,
  input  logic                lii_req_tvalid,
  output logic                lii_req_tready,
  output logic [LII_DW-1:0]   lii_resp_tdata,
  output logic [LII_DW/8-1:0] lii_resp_tkeep,
  output logic [LII_DW/8-1:0] lii_resp_tstrb,
  output logic                lii_resp_tlast,
  output logic [7:0]          lii_resp_src,
  output logic [7:0]          lii_resp_dst,
  output logic                lii_resp_tvalid,
  input  logic                lii_resp_tready,
  input  logic [7:0]          cfg_src
);

  localparam int KW       = LII_DW / 8;
  // Header layout, MSB first: op[2] len[8] size[3] addr[HDR_AW] tag[8], rest zero.
  localparam int OP_LSB   = LII_DW - 2;
  localparam int LEN_LSB  = LII_DW - 10;
  localparam int SIZE_LSB = LII_DW - 13;
  localparam int ADDR_LSB = LII_DW - 13 - HDR_AW;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_DRAIN,
    S_RD_ISS,
    S_RD_OUT,
    S_ACK
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [MEM_AW-1:0]   r_addr;
  logic [7:0]          r_src;
  // Beats seen so far; saturates so an over-long write packet cannot wrap back to "exact".
  logic [8:0]          r_cnt;

  logic                r_resp_vld;
  logic [LII_DW-1:0]   r_resp_dat;
  logic [KW-1:0]       r_resp_keep;
  logic                r_resp_last;

  logic [7:0]          r_mem [2**MEM_AW];

  logic [1:0]          w_hdr_op;
  logic [7:0]          w_hdr_len;
  logic [2:0]          w_hdr_size;
  logic [MEM_AW-1:0]   w_hdr_addr;
  logic [MEM_AW-1:0]   w_step;
  logic                w_req_fire;
  logic                w_resp_fire;
  logic                w_hdr_load;
  logic                w_wr_beat;
  logic                w_mem_we;
  logic                w_rd_issue;
  logic                w_rd_next;
  logic                w_ack_load;
  logic [1:0]          w_ack_code;
  logic                w_unused;

  assign w_hdr_op   = lii_req_tdata[OP_LSB +: 2];
  assign w_hdr_len  = lii_req_tdata[LEN_LSB +: 8];
  assign w_hdr_size = lii_req_tdata[SIZE_LSB +: 3];
  assign w_hdr_addr = lii_req_tdata[ADDR_LSB +: MEM_AW];

  // Address arithmetic is MEM_AW wide, so stepping past the top wraps to 0.
  assign w_step = {{(MEM_AW-1){1'b0}}, 1'b1} << r_size;

  // Ready is a pure state decode, held low while reset is asserted.
  assign lii_req_tready = ~rst & ((r_state == S_IDLE) | (r_state == S_WR) | (r_state == S_DRAIN));
  assign w_req_fire     = lii_req_tvalid & lii_req_tready;
  assign w_resp_fire    = r_resp_vld & lii_resp_tready;

  // Only data beats with index 0..len are committed; extra beats just advance the address.
  assign w_mem_we = w_wr_beat & lii_req_tstrb[0] & (r_cnt <= {1'b0, r_len});

  // Header keep, destination id, tag and the upper address bits carry nothing for this endpoint.
  assign w_unused = ^{lii_req_tkeep, lii_req_dst, lii_req_tdata, lii_req_tstrb};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_load  = 1'b0;
    w_wr_beat   = 1'b0;
    w_rd_issue  = 1'b0;
    w_rd_next   = 1'b0;
    w_ack_load  = 1'b0;
    w_ack_code  = RESP_OKAY;
    unique case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          w_hdr_load = 1'b1;
          case (w_hdr_op)
            OP_READ: begin
              w_state_nxt = lii_req_tlast ? S_RD_ISS : S_DRAIN;
            end
            OP_WRITE: begin
              if (lii_req_tlast) begin
                // Write header with no data beats.
                w_ack_load  = 1'b1;
                w_ack_code  = RESP_SLVERR;
                w_state_nxt = S_ACK;
              end else begin
                w_state_nxt = S_WR;
              end
            end
            default: begin
              if (lii_req_tlast) begin
                w_ack_load  = 1'b1;
                w_ack_code  = RESP_SLVERR;
                w_state_nxt = S_ACK;
              end else begin
                w_state_nxt = S_DRAIN;
              end
            end
          endcase
        end
      end
      S_WR: begin
        if (w_req_fire) begin
          w_wr_beat = 1'b1;
          if (lii_req_tlast) begin
            // r_cnt excludes this final beat: exact length means r_cnt == len.
            w_ack_load  = 1'b1;
            w_ack_code  = (r_cnt == {1'b0, r_len}) ? RESP_OKAY : RESP_SLVERR;
            w_state_nxt = S_ACK;
          end
        end
      end
      S_DRAIN: begin
        if (w_req_fire && lii_req_tlast) begin
          w_ack_load  = 1'b1;
          w_ack_code  = RESP_SLVERR;
          w_state_nxt = S_ACK;
        end
      end
      S_RD_ISS: begin
        w_rd_issue  = 1'b1;
        w_state_nxt = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (w_resp_fire) begin
          if (r_resp_last) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_rd_next   = 1'b1;
            w_state_nxt = S_RD_ISS;
          end
        end
      end
      S_ACK: begin
        if (w_resp_fire) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Transaction context and registered response fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len       <= '0;
      r_size      <= '0;
      r_addr      <= '0;
      r_src       <= '0;
      r_cnt       <= '0;
      r_resp_vld  <= 1'b0;
      r_resp_dat  <= '0;
      r_resp_keep <= '0;
      r_resp_last <= 1'b0;
    end else begin
      if (w_hdr_load) begin
        r_len  <= w_hdr_len;
        r_size <= w_hdr_size;
        r_addr <= w_hdr_addr;
        r_src  <= lii_req_src;
        r_cnt  <= '0;
      end
      if (w_wr_beat) begin
        r_addr <= r_addr + w_step;
        if (r_cnt != 9'h1FF) begin
          r_cnt <= r_cnt + 9'd1;
        end
      end
      if (w_rd_next) begin
        r_addr <= r_addr + w_step;
        r_cnt  <= r_cnt + 9'd1;
      end
      if (w_resp_fire) begin
        r_resp_vld  <= 1'b0;
        r_resp_dat  <= '0;
        r_resp_keep <= '0;
        r_resp_last <= 1'b0;
      end
      // The output data register doubles as the memory read register.
      if (w_rd_issue) begin
        r_resp_vld  <= 1'b1;
        r_resp_dat  <= {{(LII_DW-8){1'b0}}, r_mem[r_addr]};
        r_resp_keep <= {{(KW-1){1'b0}}, 1'b1};
        r_resp_last <= (r_cnt[7:0] == r_len);
      end
      if (w_ack_load) begin
        r_resp_vld  <= 1'b1;
        r_resp_dat  <= {{(LII_DW-2){1'b0}}, w_ack_code};
        r_resp_keep <= '0;
        r_resp_last <= 1'b1;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= lii_req_tdata[7:0];
    end
  end

  assign lii_resp_tvalid = r_resp_vld;
  assign lii_resp_tdata  = r_resp_dat;
  assign lii_resp_tkeep  = r_resp_keep;
  assign lii_resp_tstrb  = r_resp_keep;
  assign lii_resp_tlast  = r_resp_last;
  assign lii_resp_src    = cfg_src;
  assign lii_resp_dst    = r_src;

endmodule

// File: tb/tb_lii_mem_endpoint.sv
// Bench for lii_mem_endpoint: directed cases plus random READ/WRITE/invalid packets
// checked against a byte-array model of the endpoint memory and its response rules.
// Drives inputs #1 after posedge, samples outputs on negedge.
module tb_lii_mem_endpoint;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] lii_req_tdata = '0;
  logic [7:0]  lii_req_tkeep = '0;
  logic [7:0]  lii_req_tstrb = '0;
  logic        lii_req_tlast = 1'b0;
  logic [7:0]  lii_req_src = '0;
  logic [7:0]  lii_req_dst = '0;
  logic        lii_req_tvalid = 1'b0;
  logic        lii_req_tready;
  logic [63:0] lii_resp_tdata;
  logic [7:0]  lii_resp_tkeep;
  logic [7:0]  lii_resp_tstrb;
  logic        lii_resp_tlast;
  logic [7:0]  lii_resp_src;
  logic [7:0]  lii_resp_dst;
  logic        lii_resp_tvalid;
  logic        lii_resp_tready = 1'b0;
  logic [7:0]  cfg_src = 8'h5A;

  lii_mem_endpoint #(.LII_DW(64), .HDR_AW(40), .MEM_AW(12)) dut (
    .clk(clk), .rst(rst),
    .lii_req_tdata(lii_req_tdata), .lii_req_tkeep(lii_req_tkeep), .lii_req_tstrb(lii_req_tstrb),
    .lii_req_tlast(lii_req_tlast), .lii_req_src(lii_req_src), .lii_req_dst(lii_req_dst),
    .lii_req_tvalid(lii_req_tvalid), .lii_req_tready(lii_req_tready),
    .lii_resp_tdata(lii_resp_tdata), .lii_resp_tkeep(lii_resp_tkeep), .lii_resp_tstrb(lii_resp_tstrb),
    .lii_resp_tlast(lii_resp_tlast), .lii_resp_src(lii_resp_src), .lii_resp_dst(lii_resp_dst),
    .lii_resp_tvalid(lii_resp_tvalid), .lii_resp_tready(lii_resp_tready),
    .cfg_src(cfg_src)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  mdl [4096];
  logic [63:0] rq_dat[$];
  logic [7:0]  rq_keep[$];
  logic [7:0]  rq_strb[$];
  logic        rq_last[$];
  logic [7:0]  rq_dst[$];
  logic [7:0]  rq_src[$];
  int          first_vld;
  logic [63:0] wq[$];
  logic        wsq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] hdr(input logic [1:0] op, input logic [7:0] len,
                                      input logic [2:0] size, input logic [39:0] addr,
                                      input logic [7:0] tag);
    return {op, len, size, addr, tag, 3'b000};
  endfunction

  task automatic send_flit(input logic [63:0] d, input logic strb0, input logic last);
    int cyc;
    logic ok;
    if ($urandom % 4 == 0) begin
      @(posedge clk); #1;
    end
    lii_req_tdata  = d;
    lii_req_tkeep  = 8'($urandom);
    lii_req_tstrb  = {7'($urandom), strb0};
    lii_req_tlast  = last;
    lii_req_dst    = 8'($urandom);
    lii_req_tvalid = 1'b1;
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < 100) begin
      @(negedge clk);
      if (lii_req_tready) ok = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    lii_req_tvalid = 1'b0;
    lii_req_tlast  = 1'b0;
    lii_req_tdata  = {$urandom, $urandom};
    check("req_accept", 64'(ok), 64'h1);
  endtask

  // mode 0: always ready, 1: ready on even cycles, 2: random ready
  task automatic collect(input int mode);
    int cyc;
    logic done, held, rdy, h_last;
    logic [63:0] h_dat;
    logic [7:0]  h_keep;
    rq_dat.delete(); rq_keep.delete(); rq_strb.delete();
    rq_last.delete(); rq_dst.delete(); rq_src.delete();
    first_vld = -1;
    done = 1'b0; held = 1'b0; cyc = 0;
    h_dat = '0; h_keep = '0; h_last = 1'b0;
    while (!done && cyc < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom);
      endcase
      lii_resp_tready = rdy;
      @(negedge clk);
      if (lii_resp_tvalid) begin
        if (first_vld < 0) first_vld = cyc;
        check("busy_req_rdy", 64'(lii_req_tready), 64'h0);
        if (held) begin
          check("hold_dat", lii_resp_tdata, h_dat);
          check("hold_keep", 64'(lii_resp_tkeep), 64'(h_keep));
          check("hold_last", 64'(lii_resp_tlast), 64'(h_last));
        end
        if (rdy) begin
          rq_dat.push_back(lii_resp_tdata);
          rq_keep.push_back(lii_resp_tkeep);
          rq_strb.push_back(lii_resp_tstrb);
          rq_last.push_back(lii_resp_tlast);
          rq_dst.push_back(lii_resp_dst);
          rq_src.push_back(lii_resp_src);
          if (lii_resp_tlast) done = 1'b1;
          held = 1'b0;
        end else begin
          held = 1'b1;
          h_dat = lii_resp_tdata; h_keep = lii_resp_tkeep; h_last = lii_resp_tlast;
        end
      end else if (held) begin
        check("hold_vld", 64'(lii_resp_tvalid), 64'h1);
        held = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    lii_resp_tready = 1'b0;
    check("resp_done", 64'(done), 64'h1);
    @(negedge clk);
    check("resp_idle_after", 64'(lii_resp_tvalid), 64'h0);
    @(posedge clk); #1;
  endtask

  task automatic check_ack(input logic [1:0] code, input logic [7:0] src);
    check("ack_count", 64'(rq_dat.size()), 64'h1);
    if (rq_dat.size() > 0) begin
      check("ack_code", 64'(rq_dat[0][1:0]), 64'(code));
      check("ack_keep", 64'(rq_keep[0]), 64'h0);
      check("ack_strb", 64'(rq_strb[0]), 64'h0);
      check("ack_last", 64'(rq_last[0]), 64'h1);
      check("ack_dst", 64'(rq_dst[0]), 64'(src));
      check("ack_src", 64'(rq_src[0]), 64'(cfg_src));
    end
  endtask

  task automatic do_read(input logic [39:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input int mode);
    logic [7:0]  src;
    logic [11:0] a;
    int n;
    src = 8'($urandom);
    lii_req_src = src;
    send_flit(hdr(2'b00, len, size, addr, 8'($urandom)), 1'($urandom), 1'b1);
    collect(mode);
    n = rq_dat.size();
    check("rd_beats", 64'(n), 64'(int'(len) + 1));
    for (int i = 0; i < n && i <= int'(len); i++) begin
      a = addr[11:0] + 12'(i << size);
      check("rd_dat", rq_dat[i], {56'h0, mdl[a]});
      check("rd_keep", 64'(rq_keep[i]), 64'h01);
      check("rd_strb", 64'(rq_strb[i]), 64'h01);
      check("rd_last", 64'(rq_last[i]), 64'(i == int'(len)));
      check("rd_dst", 64'(rq_dst[i]), 64'(src));
      check("rd_src", 64'(rq_src[i]), 64'(cfg_src));
    end
  endtask

  // Data beats come from wq/wsq (data, write-enable bit).
  task automatic do_write(input logic [39:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input int nbeats, input int mode);
    logic [7:0]  src;
    logic [11:0] a;
    src = 8'($urandom);
    lii_req_src = src;
    send_flit(hdr(2'b01, len, size, addr, 8'($urandom)), 1'($urandom), nbeats == 0);
    for (int i = 0; i < nbeats; i++) begin
      send_flit(wq[i], wsq[i], i == nbeats - 1);
      a = addr[11:0] + 12'(i << size);
      if (i <= int'(len) && wsq[i]) mdl[a] = wq[i][7:0];
    end
    collect(mode);
    check_ack((nbeats == int'(len) + 1) ? 2'b00 : 2'b10, src);
  endtask

  task automatic do_bad(input logic [1:0] op, input logic [39:0] addr, input int njunk, input int mode);
    logic [7:0] src;
    src = 8'($urandom);
    lii_req_src = src;
    send_flit(hdr(op, 8'($urandom), 3'($urandom), addr, 8'h00), 1'b1, njunk == 0);
    for (int i = 0; i < njunk; i++) begin
      send_flit({$urandom, $urandom}, 1'b1, i == njunk - 1);
    end
    collect(mode);
    check_ack(2'b10, src);
  endtask

  task automatic fill_wq(input int n);
    wq.delete(); wsq.delete();
    for (int i = 0; i < n; i++) begin
      wq.push_back({$urandom, $urandom});
      wsq.push_back(($urandom % 4) != 0);
    end
  endtask

  initial begin
    logic [63:0] rv;
    logic [7:0]  len;
    int          nb, cyc, kind;
    logic        seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy", 64'(lii_req_tready), 64'h0);
    check("rst_resp_vld", 64'(lii_resp_tvalid), 64'h0);
    check("rst_resp_dat", lii_resp_tdata, 64'h0);
    check("rst_resp_keep", 64'(lii_resp_tkeep), 64'h0);
    check("rst_resp_strb", 64'(lii_resp_tstrb), 64'h0);
    check("rst_resp_last", 64'(lii_resp_tlast), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_rdy", 64'(lii_req_tready), 64'h1);
    @(posedge clk); #1;

    // Give every memory byte a known value.
    for (int blk = 0; blk < 16; blk++) begin
      wq.delete(); wsq.delete();
      for (int i = 0; i < 256; i++) begin
        wq.push_back({$urandom, $urandom});
        wsq.push_back(1'b1);
      end
      do_write(40'(blk * 256), 8'd255, 3'd0, 256, 0);
    end

    // WRITE len=3 @0x10, data 11..44
    wq.delete(); wsq.delete();
    wq.push_back(64'h11); wq.push_back(64'h22); wq.push_back(64'h33); wq.push_back(64'h44);
    repeat (4) wsq.push_back(1'b1);
    do_write(40'h10, 8'd3, 3'd0, 4, 0);
    check("ack_latency", 64'(first_vld), 64'h0);

    // READ back, always ready and then with toggling ready
    do_read(40'h10, 8'd3, 3'd0, 0);
    check("rd_latency", 64'(first_vld), 64'h1);
    if (rq_dat.size() == 4) check("rd_byte3", rq_dat[3], 64'h44);
    do_read(40'h10, 8'd3, 3'd0, 1);

    // Wrap at top of memory with one extra beat
    wq.delete(); wsq.delete();
    wq.push_back(64'hA1); wq.push_back(64'hB2); wq.push_back(64'hC3);
    repeat (3) wsq.push_back(1'b1);
    do_write(40'hFFF, 8'd1, 3'd0, 3, 0);
    do_read(40'hFFE, 8'd3, 3'd0, 0);

    // Invalid op drained, memory untouched
    do_bad(2'b11, 40'h20, 2, 0);
    do_read(40'h20, 8'd3, 3'd0, 2);
    // READ header without tlast, invalid op with tlast, WRITE header with no data
    do_bad(2'b00, 40'h30, 1, 1);
    do_bad(2'b10, 40'h30, 0, 0);
    do_write(40'h30, 8'd2, 3'd0, 0, 0);

    // Reset while a len=7 read is presenting data
    lii_req_src = 8'h77;
    send_flit(hdr(2'b00, 8'd7, 3'd0, 40'h100, 8'h00), 1'b0, 1'b1);
    lii_resp_tready = 1'b0;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      if (lii_resp_tvalid) seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_mid_vld_seen", 64'(seen), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req_rdy", 64'(lii_req_tready), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_resp_vld", 64'(lii_resp_tvalid), 64'h0);
    check("rst_mid_idle", 64'(lii_req_tready), 64'h1);
    @(posedge clk); #1;
    do_read(40'h100, 8'd7, 3'd0, 0);

    // Random traffic
    for (int t = 0; t < 60; t++) begin
      rv = {$urandom, $urandom};
      if ($urandom % 8 == 0) cfg_src = 8'($urandom);
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        do_read(rv[39:0], 8'($urandom_range(0, 15)), 3'($urandom), $urandom_range(0, 2));
      end else if (kind < 9) begin
        len = 8'($urandom_range(0, 7));
        case ($urandom % 4)
          0:       nb = int'(len);
          1:       nb = int'(len) + 2;
          default: nb = int'(len) + 1;
        endcase
        fill_wq(nb);
        do_write(rv[39:0], len, 3'($urandom), nb, $urandom_range(0, 2));
      end else begin
        do_bad(2'($urandom_range(2, 3)), rv[39:0], $urandom_range(0, 3), $urandom_range(0, 2));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
